// File: rtl/myo_spi_scheduler.sv
// Control-period scheduler for one shared myocontrol SPI master. Each period it walks the
// enabled motor boards in ascending order: select, start, wait for done (with watchdog), guard gap.
module myo_spi_scheduler #(
    parameter int NUM_MOTORS      = 7,
    parameter int PERIOD_CYCLES   = 50000,
    parameter int GAP_CYCLES      = 500,
    parameter int WATCHDOG_CYCLES = 4096,
    localparam int IDX_W          = $clog2(NUM_MOTORS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [NUM_MOTORS-1:0] motor_mask,
    output logic                  spi_start,
    input  logic                  spi_done,
    output logic [NUM_MOTORS-1:0] ss_n,
    output logic [IDX_W-1:0]      motor_index,
    output logic                  cycle_done,
    output logic [NUM_MOTORS-1:0] timeout_err,
    input  logic                  err_clear,
    output logic [15:0]           overrun_cnt,
    output logic [2:0]            state_dbg
);
    localparam int PCNT_W = $clog2(PERIOD_CYCLES);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int WD_W   = $clog2(WATCHDOG_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SELECT, START, WAIT_DONE, GAP} state_e;

    state_e                  state_q, state_d;
    logic [PCNT_W-1:0]       period_q, period_d;
    logic [NUM_MOTORS-1:0]   pend_q, pend_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    abort_q, abort_d;
    logic [NUM_MOTORS-1:0]   err_q, err_d;
    logic [15:0]             ovr_q, ovr_d;
    logic [NUM_MOTORS-1:0]   ss_n_q, ss_n_d;
    logic                    start_q, start_d;
    logic                    cdone_q, cdone_d;

    logic tick, wd_expire, gap_last, stop;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_MOTORS-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [NUM_MOTORS-1:0] select_n(input logic [IDX_W-1:0] i);
        logic [NUM_MOTORS-1:0] r;
        r    = '1;
        r[i] = 1'b0;
        return r;
    endfunction

    assign tick      = enable && (period_q == PCNT_W'(PERIOD_CYCLES - 1));
    assign wd_expire = (wd_q == WD_W'(WATCHDOG_CYCLES - 1));
    assign gap_last  = (gap_q == GAP_W'(GAP_CYCLES - 1));
    // Once enable has dropped anywhere inside a sequence, no further motor is addressed.
    assign stop      = abort_q || !enable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            period_q <= '0;
            pend_q   <= '0;
            idx_q    <= '0;
            wd_q     <= '0;
            gap_q    <= '0;
            abort_q  <= 1'b0;
            err_q    <= '0;
            ovr_q    <= '0;
            ss_n_q   <= '1;
            start_q  <= 1'b0;
            cdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            pend_q   <= pend_d;
            idx_q    <= idx_d;
            wd_q     <= wd_d;
            gap_q    <= gap_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
            ss_n_q   <= ss_n_d;
            start_q  <= start_d;
            cdone_q  <= cdone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (tick && motor_mask != '0) state_d = SELECT;
            SELECT:    state_d = START;
            START:     state_d = WAIT_DONE;
            WAIT_DONE: if (spi_done || wd_expire) state_d = GAP;
            GAP:       if (gap_last) state_d = (pend_q != '0 && !stop) ? SELECT : IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        period_d = (!enable || period_q == PCNT_W'(PERIOD_CYCLES - 1)) ? '0 : period_q + PCNT_W'(1);
        pend_d   = pend_q;
        idx_d    = idx_q;
        wd_d     = wd_q;
        gap_d    = gap_q;
        ss_n_d   = ss_n_q;
        start_d  = 1'b0;
        cdone_d  = 1'b0;
        abort_d  = (state_q == IDLE) ? 1'b0 : (abort_q || !enable);
        // A clear coinciding with a new event keeps the new event.
        err_d    = err_clear ? '0 : err_q;
        ovr_d    = err_clear ? '0 : ovr_q;
        if (tick && state_q != IDLE && ovr_d != 16'hFFFF) ovr_d = ovr_d + 16'd1;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    pend_d = motor_mask;
                    if (motor_mask == '0) begin
                        cdone_d = 1'b1;
                    end else begin
                        idx_d  = lowest_set(motor_mask);
                        ss_n_d = select_n(lowest_set(motor_mask));
                    end
                end
            end
            SELECT: start_d = 1'b1;
            START:  wd_d = '0;
            WAIT_DONE: begin
                wd_d = wd_q + WD_W'(1);
                if (spi_done || wd_expire) begin
                    ss_n_d        = '1;
                    gap_d         = '0;
                    pend_d[idx_q] = 1'b0;
                    if (!spi_done) err_d[idx_q] = 1'b1;
                end
            end
            GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_last) begin
                    if (pend_q != '0 && !stop) begin
                        idx_d  = lowest_set(pend_q);
                        ss_n_d = select_n(lowest_set(pend_q));
                    end else if (!stop) begin
                        cdone_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign spi_start   = start_q;
    assign ss_n        = ss_n_q;
    assign motor_index = idx_q;
    assign cycle_done  = cdone_q;
    assign timeout_err = err_q;
    assign overrun_cnt = ovr_q;
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_myo_spi_scheduler.sv
// Bench for myo_spi_scheduler: an SPI-engine responder plus an event timeline model that
// predicts every select, start, release and cycle_done cycle from the scheduling rules.
module tb_myo_spi_scheduler;
  localparam int NM = 7;
  localparam int P  = 100;
  localparam int G  = 8;
  localparam int W  = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [NM-1:0] motor_mask = '0;
  logic          spi_start;
  logic          spi_done = 1'b0;
  logic [NM-1:0] ss_n;
  logic [2:0]    motor_index;
  logic          cycle_done;
  logic [NM-1:0] timeout_err;
  logic          err_clear = 1'b0;
  logic [15:0]   overrun_cnt;
  logic [2:0]    state_dbg;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] act_q[$];
  int delay_tab[NM];
  int done_at = -1;
  int stray_at = -1;
  bit mon_en = 1'b0;
  logic [NM-1:0] prev_ss = '1;

  myo_spi_scheduler #(
    .NUM_MOTORS(NM), .PERIOD_CYCLES(P), .GAP_CYCLES(G), .WATCHDOG_CYCLES(W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .motor_mask(motor_mask),
    .spi_start(spi_start), .spi_done(spi_done), .ss_n(ss_n), .motor_index(motor_index),
    .cycle_done(cycle_done), .timeout_err(timeout_err), .err_clear(err_clear),
    .overrun_cnt(overrun_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // event word: {type, motor, cycle}; 1=select 2=start 3=release 4=cycle_done
  function automatic logic [31:0] ev(input int t, input int m, input int c);
    return {t[3:0], m[3:0], c[23:0]};
  endfunction

  function automatic int low_idx(input logic [NM-1:0] v);
    int r;
    r = 0;
    for (int i = NM - 1; i >= 0; i--) if (!v[i]) r = i;
    return r;
  endfunction

  // SPI engine responder: done pulse delay_tab[m] cycles after start (0 = never answers)
  always @(negedge clk) begin
    spi_done = (cyc == done_at) || (cyc == stray_at);
    if (spi_start && delay_tab[low_idx(ss_n)] > 0) done_at = cyc + delay_tab[low_idx(ss_n)];
  end

  // monitor: collects observed events, checks the one-hot-low rule on ss_n
  always @(negedge clk) begin
    if (mon_en) begin
      if (ss_n != '1 && prev_ss == '1) act_q.push_back(ev(1, low_idx(ss_n), cyc));
      if (ss_n == '1 && prev_ss != '1) act_q.push_back(ev(3, low_idx(prev_ss), cyc));
      if (spi_start) act_q.push_back(ev(2, int'(motor_index), cyc));
      if (cycle_done) act_q.push_back(ev(4, 0, cyc));
      n_cmp++;
      if ($countones(~ss_n) > 1) begin
        n_fail++;
        $display("FAIL ss_onehot: ss_n=%b at cycle %0d, required at most one low", ss_n, cyc);
      end
      prev_ss = ss_n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b0; enable = 1'b0; err_clear = 1'b0; motor_mask = '0;
    done_at = -1; stray_at = -1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run(input logic [NM-1:0] mask, input int len, input int clear_off,
                     output int e, output int x);
    act_q.delete(); exp_q.delete(); prev_ss = '1; mon_en = 1'b1;
    @(negedge clk);
    motor_mask = mask; enable = 1'b1; e = cyc;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      err_clear = (clear_off >= 0) && (cyc == e + clear_off);
    end
    enable = 1'b0; err_clear = 1'b0; x = cyc;
  endtask

  task automatic settle(input int last);
    for (int i = 0; i < 2000 && cyc < last + 3; i++) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Enable high during cycles [e, x). Ticks every P cycles; a sequence walks masked motors
  // in order; overlapping ticks count as overruns; a drop of enable ends it after the gap.
  task automatic model(input int e, input int x, input logic [NM-1:0] mask,
                       output int last, output int n_ovr, output logic [NM-1:0] errs);
    int free, t, s, h, d;
    bit ab;
    free = 0; last = e; n_ovr = 0; errs = '0;
    for (int tk = e + P - 1; tk < x; tk += P) begin
      if (tk < free) begin
        n_ovr++;
      end else if (mask == '0) begin
        exp_q.push_back(ev(4, 0, tk + 1));
        free = tk + 1; last = tk + 1;
      end else begin
        t = tk + 1; ab = 1'b0;
        for (int m = 0; m < NM; m++) begin
          if (mask[m] && !ab) begin
            s = t + 1; d = delay_tab[m];
            exp_q.push_back(ev(1, m, t));
            exp_q.push_back(ev(2, m, s));
            if (d > 0 && d <= W) h = s + d + 1;
            else begin h = s + W + 1; errs[m] = 1'b1; end
            exp_q.push_back(ev(3, m, h));
            t = h + G;
            if (x <= t - 1) ab = 1'b1;
          end
        end
        if (!ab) exp_q.push_back(ev(4, 0, t));
        free = t; last = t;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ss_n !== 7'h7F) begin n_fail++; $display("FAIL reset_ss_n: got %b required 1111111", ss_n); end
    n_cmp++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b required 0", spi_start); end
    n_cmp++; if (cycle_done !== 1'b0) begin n_fail++; $display("FAIL reset_cdone: got %b required 0", cycle_done); end
    n_cmp++; if (motor_index !== 3'd0) begin n_fail++; $display("FAIL reset_index: got %0d required 0", motor_index); end
    n_cmp++; if (timeout_err !== 7'h00) begin n_fail++; $display("FAIL reset_err: got %b required 0", timeout_err); end
    n_cmp++; if (overrun_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_ovr: got %0d required 0", overrun_cnt); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int e, x, last, nov;
    logic [NM-1:0] errs;
    do_reset();
    for (int m = 0; m < NM; m++) delay_tab[m] = 10;
    stray_at = cyc + 5;
    run(7'b0000101, 150, -1, e, x);
    model(e, x, 7'b0000101, last, nov, errs);
    settle(last);
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_count: got %0d events required %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      n_cmp++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_ev%0d: got %h required %h", i, act_q[i], exp_q[i]); end
    end
    n_cmp++; if (timeout_err !== 7'h00) begin n_fail++; $display("FAIL basic_err: got %b required 0", timeout_err); end
    n_cmp++; if (overrun_cnt !== 16'd0) begin n_fail++; $display("FAIL basic_ovr: got %0d required 0", overrun_cnt); end
  endtask

  task automatic test_empty_mask();
    int e, x, last, nov;
    logic [NM-1:0] errs;
    do_reset();
    run('0, 350, -1, e, x);
    model(e, x, '0, last, nov, errs);
    settle(last);
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL empty_count: got %0d events required %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      n_cmp++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL empty_ev%0d: got %h required %h", i, act_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    int e, x, last, nov;
    logic [NM-1:0] errs;
    do_reset();
    for (int m = 0; m < NM; m++) delay_tab[m] = 10;
    delay_tab[3] = 0;
    run(7'b0011000, 196, -1, e, x);
    model(e, x, 7'b0011000, last, nov, errs);
    settle(last);
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL tmo_count: got %0d events required %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      n_cmp++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL tmo_ev%0d: got %h required %h", i, act_q[i], exp_q[i]); end
    end
    n_cmp++; if (timeout_err !== 7'b0001000) begin n_fail++; $display("FAIL tmo_err: got %b required 0001000", timeout_err); end
    pulse_clear();
    n_cmp++; if (timeout_err !== 7'h00) begin n_fail++; $display("FAIL tmo_clear: got %b required 0", timeout_err); end
    // motors 3 and 5 both silent; clear lands on motor 5's expiry cycle
    delay_tab[5] = 0;
    run(7'b0101000, 250, P + 1 + W + 74, e, x);
    model(e, x, 7'b0101000, last, nov, errs);
    settle(last);
    n_cmp++; if (timeout_err !== 7'b0100000) begin n_fail++; $display("FAIL tmo_race: got %b required 0100000", timeout_err); end
    n_cmp++; if (overrun_cnt !== 16'd0) begin n_fail++; $display("FAIL tmo_race_ovr: got %0d required 0", overrun_cnt); end
  endtask

  task automatic test_overrun();
    int e, x, last, nov;
    logic [NM-1:0] errs;
    do_reset();
    for (int m = 0; m < NM; m++) delay_tab[m] = 50;
    run(7'h7F, 560, -1, e, x);
    model(e, x, 7'h7F, last, nov, errs);
    settle(last);
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovr_count: got %0d events required %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      n_cmp++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovr_ev%0d: got %h required %h", i, act_q[i], exp_q[i]); end
    end
    n_cmp++; if (overrun_cnt !== 16'(nov)) begin n_fail++; $display("FAIL ovr_value: got %0d required %0d", overrun_cnt, nov); end
    @(negedge clk); force dut.ovr_q = 16'hFFFF;
    @(negedge clk); release dut.ovr_q;
    run(7'h7F, 560, -1, e, x);
    model(e, x, 7'h7F, last, nov, errs);
    settle(last);
    n_cmp++; if (overrun_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL ovr_sat: got %h required ffff", overrun_cnt); end
    // clear on the first missed tick: that tick still counts
    run(7'h7F, 560, P - 1 + P, e, x);
    model(e, x, 7'h7F, last, nov, errs);
    settle(last);
    n_cmp++; if (overrun_cnt !== 16'(nov)) begin n_fail++; $display("FAIL ovr_race: got %0d required %0d", overrun_cnt, nov); end
    pulse_clear();
    n_cmp++; if (overrun_cnt !== 16'd0) begin n_fail++; $display("FAIL ovr_clear: got %0d required 0", overrun_cnt); end
  endtask

  task automatic test_enable_drop();
    int e, x, last, nov;
    logic [NM-1:0] errs;
    do_reset();
    for (int m = 0; m < NM; m++) delay_tab[m] = 20;
    run(7'b0000110, P + 9, -1, e, x);
    model(e, x, 7'b0000110, last, nov, errs);
    settle(last + G);
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL drop_count: got %0d events required %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      n_cmp++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL drop_ev%0d: got %h required %h", i, act_q[i], exp_q[i]); end
    end
    run(7'b0000110, 180, -1, e, x);
    model(e, x, 7'b0000110, last, nov, errs);
    settle(last);
    n_cmp++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL reen_count: got %0d events required %0d", act_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < act_q.size()) begin
      n_cmp++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL reen_ev%0d: got %h required %h", i, act_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int e;
    do_reset();
    delay_tab[0] = 0;
    @(negedge clk);
    motor_mask = 7'b0000001; enable = 1'b1; e = cyc;
    for (int i = 0; i < 500 && cyc < e + P + 10; i++) @(negedge clk);
    n_cmp++; if (ss_n !== 7'b1111110) begin n_fail++; $display("FAIL mid_selected: got %b required 1111110", ss_n); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (ss_n !== 7'h7F) begin n_fail++; $display("FAIL mid_ss_n: got %b required 1111111", ss_n); end
    n_cmp++; if (spi_start !== 1'b0 || cycle_done !== 1'b0) begin n_fail++; $display("FAIL mid_pulses: got %b%b required 00", spi_start, cycle_done); end
    n_cmp++; if (motor_index !== 3'd0 || timeout_err !== 7'h00 || overrun_cnt !== 16'd0) begin
      n_fail++; $display("FAIL mid_state: got idx %0d err %b ovr %0d required 0 0 0", motor_index, timeout_err, overrun_cnt);
    end
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    int e, x, last, nov, len;
    logic [NM-1:0] errs, mask;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      mask = NM'($urandom_range(0, 127));
      for (int m = 0; m < NM; m++) delay_tab[m] = $urandom_range(0, W + 8);
      len = $urandom_range(150, 400);
      run(mask, len, -1, e, x);
      model(e, x, mask, last, nov, errs);
      settle(last);
      n_cmp++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd%0d_count: got %0d events required %0d", it, act_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < act_q.size()) begin
        n_cmp++; if (act_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_ev%0d: got %h required %h", it, i, act_q[i], exp_q[i]); end
      end
      n_cmp++; if (timeout_err !== errs) begin n_fail++; $display("FAIL rnd%0d_err: got %b required %b", it, timeout_err, errs); end
      n_cmp++; if (overrun_cnt !== 16'(nov)) begin n_fail++; $display("FAIL rnd%0d_ovr: got %0d required %0d", it, overrun_cnt, nov); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int m = 0; m < NM; m++) delay_tab[m] = 10;
    test_reset();
    test_basic();
    test_empty_mask();
    test_timeout();
    test_overrun();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
